// File: rtl/mii_byte_collect.sv
// mii_byte_collect
//   Reassembles the deframed MII nibble stream into bytes, low nibble first.
//   It emits one byte strobe per complete byte, marking the first byte of
//   each frame. It then emits a single end-of-frame pulse carrying the frame
//   status.
//
// Ports
//   clk, rst_n     receive clock, async active-low reset
//   rx_d, rx_dv    deframed nibble and its valid (frame = rx_dv high run)
//   rx_fcs_ok      FCS-good, sampled in the first rx_dv-low cycle of a frame
//   byte_data      assembled byte {hi, lo}; holds between strobes
//   byte_stb       one-cycle byte strobe
//   byte_sof       with byte_stb on the first byte of a frame
//   eof            one-cycle pulse; the status outputs below update with it
//   frame_len      complete bytes counted, saturating at MAX_LEN+1
//   frame_ok       fcs ok, no odd nibble, length legal
//   err_odd        frame ended on an unpaired low nibble
//   err_len        length < MIN_LEN or > MAX_LEN
module mii_byte_collect #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rx_d,
  input  logic             rx_dv,
  input  logic             rx_fcs_ok,
  output logic [7:0]       byte_data,
  output logic             byte_stb,
  output logic             byte_sof,
  output logic             eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_ok,
  output logic             err_odd,
  output logic             err_len
);

  localparam logic [LEN_W-1:0] MIN_C  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_C  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] SAT_C  = LEN_W'(MAX_LEN + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HI, LO} state_t;

  state_t           state, state_nxt;
  logic [3:0]       low_nib;
  logic [LEN_W-1:0] cnt;
  logic             start, take_lo, take_hi, end_frame;
  logic             odd_now, len_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nxt;
  end

  // END is not a state of its own: it is the rx_dv-low sample taken in HI/LO.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take_lo   = 1'b0;
    take_hi   = 1'b0;
    end_frame = 1'b0;
    case (state)
      SYNC: if (!rx_dv) state_nxt = IDLE;
      IDLE: if (rx_dv) begin
        start     = 1'b1;
        take_lo   = 1'b1;
        state_nxt = HI;
      end
      HI: if (rx_dv) begin
        take_hi   = 1'b1;
        state_nxt = LO;
      end else begin
        end_frame = 1'b1;
        state_nxt = IDLE;
      end
      LO: if (rx_dv) begin
        take_lo   = 1'b1;
        state_nxt = HI;
      end else begin
        end_frame = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Ending in HI means a low nibble is still waiting for its partner.
  assign odd_now = (state == HI);
  assign len_bad = (cnt < MIN_C) || (cnt > MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_nib   <= '0;
      cnt       <= '0;
      byte_data <= '0;
      byte_stb  <= 1'b0;
      byte_sof  <= 1'b0;
      eof       <= 1'b0;
      frame_len <= '0;
      frame_ok  <= 1'b0;
      err_odd   <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      byte_sof <= 1'b0;
      eof      <= 1'b0;
      if (take_lo) low_nib <= rx_d;
      if (start)   cnt     <= '0;
      if (take_hi) begin
        if (cnt < MAX_C) begin
          byte_data <= {rx_d, low_nib};
          byte_stb  <= 1'b1;
          byte_sof  <= (cnt == '0);
          cnt       <= cnt + 1'b1;
        end else begin
          // Oversize: stop strobing, park the count one past the limit.
          cnt <= SAT_C;
        end
      end
      if (end_frame) begin
        eof       <= 1'b1;
        frame_len <= cnt;
        err_odd   <= odd_now;
        err_len   <= len_bad;
        frame_ok  <= rx_fcs_ok & ~odd_now & ~len_bad;
      end
    end
  end

endmodule

// File: tb/tb_mii_byte_collect.sv
// tb_mii_byte_collect
//   Directed frames drive the nibble stream. Expected bytes and end-of-frame
//   status are queued at stimulus time. A negedge monitor pops and compares
//   each queued entry when the DUT strobes.
module tb_mii_byte_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rx_d = '0;
  logic        rx_dv = 1'b0;
  logic        rx_fcs_ok = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_stb, byte_sof, eof;
  logic [10:0] frame_len;
  logic        frame_ok, err_odd, err_len;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic sof; logic [7:0] d; } bexp_t;
  typedef struct { int len; bit ok; bit odd; bit lerr; bit stb_prev; } eexp_t;

  bexp_t bq[$];
  eexp_t eq[$];

  always #5 clk = ~clk;

  mii_byte_collect #(.MIN_LEN(60), .MAX_LEN(1514), .LEN_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_dv(rx_dv), .rx_fcs_ok(rx_fcs_ok),
    .byte_data(byte_data), .byte_stb(byte_stb), .byte_sof(byte_sof), .eof(eof),
    .frame_len(frame_len), .frame_ok(frame_ok), .err_odd(err_odd), .err_len(err_len)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame content: 08 00 20 0A 70 66, filler, last two bytes 20 20.
  function automatic logic [7:0] fbyte(input int i, input int n);
    if (i >= n - 2) return 8'h20;
    case (i)
      0: return 8'h08;
      1: return 8'h00;
      2: return 8'h20;
      3: return 8'h0A;
      4: return 8'h70;
      5: return 8'h66;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  task automatic nib(input logic [3:0] d);
    @(posedge clk);
    #1;
    rx_d  = d;
    rx_dv = 1'b1;
  endtask

  task automatic drop(input logic fcs, input int gap);
    @(posedge clk);
    #1;
    rx_dv     = 1'b0;
    rx_fcs_ok = fcs;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int n, input bit stray, input bit fcs, input int gap);
    logic [7:0] b;
    eexp_t e;
    for (int i = 0; i < n; i++) begin
      b = fbyte(i, n);
      nib(b[3:0]);
      nib(b[7:4]);
      if (i < 1514) bq.push_back({(i == 0), b});
    end
    if (stray) nib(4'h5);
    e.len      = (n > 1514) ? 1515 : n;
    e.odd      = stray;
    e.lerr     = (e.len < 60) || (e.len > 1514);
    e.ok       = fcs && !stray && !e.lerr;
    e.stb_prev = !stray && (n <= 1514);
    eq.push_back(e);
    drop(fcs, gap);
  endtask

  // Monitor: status held between eofs; byte_stb and eof never coincide.
  int  h_len;
  bit  h_ok, h_odd, h_lerr, prev_stb;
  always @(negedge clk) begin
    if (!rst_n) begin
      h_len = 0; h_ok = 0; h_odd = 0; h_lerr = 0; prev_stb = 0;
    end else begin
      if (byte_stb && eof) chk("stb_eof_overlap", 1, 0);
      if (byte_stb) begin
        if (bq.size() == 0) chk("unexpected_byte", 32'(byte_data), -1);
        else begin
          bexp_t x;
          x = bq.pop_front();
          chk("byte_data", 32'(byte_data), 32'(x.d));
          chk("byte_sof", 32'(byte_sof), 32'(x.sof));
        end
      end
      if (eof) begin
        if (eq.size() == 0) chk("unexpected_eof", 32'(frame_len), -1);
        else begin
          eexp_t e;
          e = eq.pop_front();
          chk("frame_len", 32'(frame_len), e.len);
          chk("frame_ok", 32'(frame_ok), 32'(e.ok));
          chk("err_odd", 32'(err_odd), 32'(e.odd));
          chk("err_len", 32'(err_len), 32'(e.lerr));
          if (e.stb_prev) chk("last_stb_before_eof", 32'(prev_stb), 1);
          h_len = e.len; h_ok = e.ok; h_odd = e.odd; h_lerr = e.lerr;
        end
      end else begin
        chk("status_hold", {21'd0, frame_len, frame_ok, err_odd, err_len},
            {h_len[10:0], h_ok, h_odd, h_lerr});
      end
      prev_stb = byte_stb;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    #1;
    chk("reset_outputs", {byte_data, byte_stb, byte_sof, eof, frame_len, frame_ok, err_odd, err_len}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send_frame(60, 0, 1, 3);     // nominal
    send_frame(60, 0, 0, 3);     // bad FCS
    send_frame(60, 1, 1, 3);     // stray nibble
    send_frame(20, 0, 1, 3);     // runt
    send_frame(1520, 0, 1, 1);   // oversize, then 1-cycle gap
    send_frame(60, 0, 1, 3);

    // Reset mid-frame at byte 30 with rx_dv held high.
    for (int i = 0; i < 30; i++) begin
      b = fbyte(i, 60);
      nib(b[3:0]);
      nib(b[7:4]);
      bq.push_back({(i == 0), b});
    end
    b = fbyte(30, 60);
    nib(b[3:0]);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {byte_data, byte_stb, byte_sof, eof, frame_len, frame_ok, err_odd, err_len}, 0);
    nib(b[7:4]);
    for (int i = 31; i < 60; i++) begin
      b = fbyte(i, 60);
      nib(b[3:0]);
      if (i == 32) rst_n = 1'b1;
      nib(b[7:4]);
    end
    drop(1, 3);                  // no eof expected for the aborted frame
    send_frame(60, 0, 1, 3);

    repeat (6) @(posedge clk);
    chk("bytes_outstanding", bq.size(), 0);
    chk("eofs_outstanding", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
